// File: rtl/mcu_bus_sequencer_if.sv
// MCU-facing parallel bus: strobe, direction, address, pad data and the
// four-phase acknowledge. The MCU is the master, the sequencer the slave.
interface mcu_bus_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          mcu_mstr;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          fpga_ack;

  modport master (
    output mcu_mstr, write_enable, address, data_in,
    input  data_out, data_oe, fpga_ack
  );

  modport slave (
    input  mcu_mstr, write_enable, address, data_in,
    output data_out, data_oe, fpga_ack
  );
endinterface

// File: rtl/mcu_bus_sequencer.sv
// Sequencer/arbiter for the pin-state register bank. Serves the MCU
// four-phase bus and one fabric requester, alternating on ties, and is the
// only driver of the bank write port and of the pad output enable.
module mcu_bus_sequencer #(
  parameter int NREG = 17,
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic          CLK50,
  input  logic          RST_N,
  mcu_bus_sequencer_if.slave bus,
  input  logic          int_req,
  input  logic          int_we,
  input  logic [AW-1:0] int_addr,
  input  logic [DW-1:0] int_wdata,
  output logic          int_done,
  output logic [DW-1:0] int_rdata,
  output logic          reg_we,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          addr_err
);

  typedef enum logic [2:0] {
    IDLE, MCU_SETUP, MCU_ACCESS, MCU_ACK, INT_ACCESS, INT_DONE
  } state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(NREG);

  function automatic logic in_rng(input logic [AW-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  state_t        state;
  logic [SYNC-1:0] sync_q;
  logic          mstr_s;
  logic          last_mcu;   // 1 = MCU was the side served last
  logic          we_q;
  logic          rng_q;
  logic [DW-1:0] dout_q;
  logic          oe_q;
  logic          ack_q;

  assign mstr_s       = sync_q[SYNC-1];
  assign bus.data_out = dout_q;
  assign bus.data_oe  = oe_q;
  assign bus.fpga_ack = ack_q;

  // Bring the asynchronous MCU strobe into the CLK50 domain.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC-2:0], bus.mcu_mstr};
  end

  // Arbitration and transaction sequencing. Address/data are latched on
  // the grant edge so they are stable for the whole setup/access phase;
  // reg_we, addr_err and int_done are single-cycle pulses.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      last_mcu  <= 1'b1;
      we_q      <= 1'b0;
      rng_q     <= 1'b0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      int_done  <= 1'b0;
      int_rdata <= '0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      addr_err  <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      addr_err <= 1'b0;
      int_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mstr_s && (!int_req || !last_mcu)) begin
            state     <= MCU_SETUP;
            last_mcu  <= 1'b1;
            we_q      <= bus.write_enable;
            rng_q     <= in_rng(bus.address);
            reg_addr  <= bus.address;
            reg_wdata <= bus.data_in;
            reg_we    <= bus.write_enable && in_rng(bus.address);
          end else if (int_req) begin
            state     <= INT_ACCESS;
            last_mcu  <= 1'b0;
            we_q      <= int_we;
            rng_q     <= in_rng(int_addr);
            reg_addr  <= int_addr;
            reg_wdata <= int_wdata;
            reg_we    <= int_we && in_rng(int_addr);
            addr_err  <= !in_rng(int_addr);
          end
        end
        MCU_SETUP: begin
          state    <= MCU_ACCESS;
          addr_err <= !rng_q;
        end
        MCU_ACCESS: begin
          state <= MCU_ACK;
          ack_q <= 1'b1;
          if (!we_q) begin
            dout_q <= rng_q ? reg_rdata : '1;
            oe_q   <= 1'b1;
          end
        end
        MCU_ACK: begin
          // Bus is released together with the ack once the strobe is gone.
          if (!mstr_s) begin
            ack_q <= 1'b0;
            oe_q  <= 1'b0;
            state <= IDLE;
          end
        end
        INT_ACCESS: begin
          state    <= INT_DONE;
          int_done <= 1'b1;
          if (!we_q) int_rdata <= rng_q ? reg_rdata : '1;
        end
        INT_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_bus_sequencer.sv
// Directed bench for mcu_bus_sequencer with a small register-bank model.
module tb_mcu_bus_sequencer;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          CLK50;
  logic          RST_N;
  logic          int_req, int_we;
  logic [AW-1:0] int_addr;
  logic [DW-1:0] int_wdata;
  logic          int_done;
  logic [DW-1:0] int_rdata;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          addr_err;
  logic [DW-1:0] bank [0:31];

  int tests = 0;
  int fails = 0;

  mcu_bus_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  mcu_bus_sequencer #(.NREG(17), .AW(AW), .DW(DW), .SYNC(2)) dut (
    .CLK50    (CLK50),
    .RST_N    (RST_N),
    .bus      (bus),
    .int_req  (int_req),
    .int_we   (int_we),
    .int_addr (int_addr),
    .int_wdata(int_wdata),
    .int_done (int_done),
    .int_rdata(int_rdata),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .addr_err (addr_err)
  );

  initial CLK50 = 1'b0;
  always #10 CLK50 = ~CLK50;

  // Register bank: combinational read, clocked write, two preset cells.
  assign reg_rdata = bank[reg_addr];
  always @(posedge CLK50) begin
    if (!RST_N) begin
      bank[16] <= 8'h3C;
      bank[20] <= 8'h42;
    end else if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
    end
  end

  task automatic tick;
    @(posedge CLK50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    bus.mcu_mstr = 1'b0; bus.write_enable = 1'b0;
    bus.address = '0;    bus.data_in = '0;
    int_req = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;
    tick; tick;
    chk("rst_dout",  bus.data_out, 0);
    chk("rst_oe",    bus.data_oe, 0);
    chk("rst_ack",   bus.fpga_ack, 0);
    chk("rst_idone", int_done, 0);
    chk("rst_irdat", int_rdata, 0);
    chk("rst_we",    reg_we, 0);
    chk("rst_addr",  reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_aerr",  addr_err, 0);
    RST_N = 1'b1;
    tick;

    // MCU write addr 5 <= A5
    bus.address = 5; bus.data_in = 8'hA5; bus.write_enable = 1'b1; bus.mcu_mstr = 1'b1;
    tick; tick;
    chk("wr_c0_we", reg_we, 0);
    tick;
    chk("wr_c1_we", reg_we, 1);
    chk("wr_c1_addr", reg_addr, 5);
    chk("wr_c1_wdata", reg_wdata, 8'hA5);
    chk("wr_c1_ack", bus.fpga_ack, 0);
    tick;
    chk("wr_c2_we", reg_we, 0);
    chk("wr_c2_ack", bus.fpga_ack, 0);
    tick;
    chk("wr_c3_ack", bus.fpga_ack, 1);
    chk("wr_c3_oe", bus.data_oe, 0);
    chk("wr_c3_aerr", addr_err, 0);
    bus.mcu_mstr = 1'b0;
    tick; tick;
    chk("wr_hold_ack", bus.fpga_ack, 1);
    tick;
    chk("wr_rel_ack", bus.fpga_ack, 0);

    // MCU read addr 16 -> 3C
    bus.address = 16; bus.write_enable = 1'b0; bus.mcu_mstr = 1'b1;
    tick; tick; tick;
    chk("rd16_c1_we", reg_we, 0);
    chk("rd16_c1_addr", reg_addr, 16);
    tick;
    chk("rd16_c2_oe", bus.data_oe, 0);
    tick;
    chk("rd16_c3_oe", bus.data_oe, 1);
    chk("rd16_c3_dout", bus.data_out, 8'h3C);
    chk("rd16_c3_ack", bus.fpga_ack, 1);
    bus.mcu_mstr = 1'b0;
    tick; tick;
    chk("rd16_hold_oe", bus.data_oe, 1);
    tick;
    chk("rd16_rel_ack", bus.fpga_ack, 0);
    chk("rd16_rel_oe", bus.data_oe, 0);

    // MCU read addr 20 (out of range)
    bus.address = 20; bus.mcu_mstr = 1'b1;
    tick; tick; tick;
    chk("rd20_c1_we", reg_we, 0);
    chk("rd20_c1_aerr", addr_err, 0);
    tick;
    chk("rd20_c2_aerr", addr_err, 1);
    chk("rd20_c2_we", reg_we, 0);
    tick;
    chk("rd20_c3_aerr", addr_err, 0);
    chk("rd20_c3_dout", bus.data_out, 8'hFF);
    chk("rd20_c3_ack", bus.fpga_ack, 1);
    bus.mcu_mstr = 1'b0;
    tick; tick; tick;
    chk("rd20_rel_ack", bus.fpga_ack, 0);

    // Tie after reset: internal write 3 <= 77 first, then MCU read 3
    RST_N = 1'b0; tick; RST_N = 1'b1; tick;
    bus.address = 3; bus.write_enable = 1'b0; bus.mcu_mstr = 1'b1;
    tick; tick;
    int_req = 1'b1; int_we = 1'b1; int_addr = 3; int_wdata = 8'h77;
    tick;
    chk("tie1_int_we", reg_we, 1);
    chk("tie1_int_addr", reg_addr, 3);
    chk("tie1_int_wdata", reg_wdata, 8'h77);
    tick;
    chk("tie1_int_done", int_done, 1);
    int_req = 1'b0;
    tick;
    chk("tie1_idone_clr", int_done, 0);
    chk("tie1_ack_pend", bus.fpga_ack, 0);
    tick;
    chk("tie1_mcu_addr", reg_addr, 3);
    chk("tie1_mcu_we", reg_we, 0);
    tick; tick;
    chk("tie1_mcu_ack", bus.fpga_ack, 1);
    chk("tie1_mcu_dout", bus.data_out, 8'h77);
    bus.mcu_mstr = 1'b0;
    tick; tick; tick;
    chk("tie1_rel_ack", bus.fpga_ack, 0);

    // Internal write 0 <= 11 held: int_done every 3 cycles, MCU interleaves
    int_req = 1'b1; int_we = 1'b1; int_addr = 0; int_wdata = 8'h11;
    tick;
    chk("il_q1_we", reg_we, 1);
    tick;
    chk("il_q2_done", int_done, 1);
    tick;
    chk("il_q3_done", int_done, 0);
    tick; tick;
    chk("il_q5_done", int_done, 1);
    tick; tick; tick;
    chk("il_q8_done", int_done, 1);
    bus.address = 0; bus.write_enable = 1'b0; bus.mcu_mstr = 1'b1;
    tick; tick; tick;
    chk("il_q11_done", int_done, 1);
    tick; tick;
    chk("il_q13_mcu_we", reg_we, 0);
    chk("il_q13_mcu_addr", reg_addr, 0);
    tick; tick;
    chk("il_q15_ack", bus.fpga_ack, 1);
    chk("il_q15_dout", bus.data_out, 8'h11);
    chk("il_q15_done", int_done, 0);
    bus.mcu_mstr = 1'b0;
    tick; tick; tick;
    chk("il_q18_ack", bus.fpga_ack, 0);
    tick;
    chk("il_q19_we", reg_we, 1);
    tick;
    chk("il_q20_done", int_done, 1);
    int_req = 1'b0;

    // Tie with internal served last: MCU read 16 wins, then internal read 5
    bus.address = 16; bus.mcu_mstr = 1'b1;
    tick; tick;
    int_req = 1'b1; int_we = 1'b0; int_addr = 5;
    tick;
    chk("tie2_mcu_addr", reg_addr, 16);
    tick; tick;
    chk("tie2_ack", bus.fpga_ack, 1);
    chk("tie2_dout", bus.data_out, 8'h3C);
    chk("tie2_idone", int_done, 0);
    bus.mcu_mstr = 1'b0;
    tick; tick; tick;
    chk("tie2_rel_ack", bus.fpga_ack, 0);
    tick;
    chk("tie2_int_addr", reg_addr, 5);
    tick;
    chk("tie2_int_done", int_done, 1);
    chk("tie2_int_rdata", int_rdata, 8'hA5);
    int_req = 1'b0;
    tick;
    chk("tie2_idone_clr", int_done, 0);

    // Reset during MCU_ACK of a read, strobe kept high
    bus.address = 16; bus.write_enable = 1'b0; bus.mcu_mstr = 1'b1;
    tick; tick; tick; tick; tick;
    chk("rm_ack", bus.fpga_ack, 1);
    chk("rm_oe", bus.data_oe, 1);
    #5;
    RST_N = 1'b0;
    #1;
    chk("rm_async_oe", bus.data_oe, 0);
    chk("rm_async_ack", bus.fpga_ack, 0);
    chk("rm_async_dout", bus.data_out, 0);
    tick;
    RST_N = 1'b1;
    tick; tick; tick; tick;
    chk("rm_new_c2_ack", bus.fpga_ack, 0);
    tick;
    chk("rm_new_c3_ack", bus.fpga_ack, 1);
    chk("rm_new_c3_dout", bus.data_out, 8'h3C);
    bus.mcu_mstr = 1'b0;
    tick; tick; tick;
    chk("rm_new_rel", bus.fpga_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcu_bus_sequencer.md
# mcu_bus_sequencer

Sequencer and arbiter for the pin-state register bank behind the MCU–FPGA parallel bus. It synchronizes the MCU strobe, runs a four-phase request/acknowledge transaction, and owns the tristate enable of the shared data pins. It also shares the register bank with one FPGA-internal requester. Only this block drives the bank's write port, so MCU and fabric accesses never collide.

## Interface
- NREG, 17: number of 8-bit pin-state registers; valid addresses 0..NREG-1
- AW, 5: address width
- DW, 8: data width
- SYNC, 2: synchronizer depth for mcu_mstr (≥2)

- CLK50  in  1  system clock, 50 MHz
- RST_N  in  1  reset; one clock, asynchronous assert, active-low
- mcu_mstr  in  1  MCU transaction strobe, asynchronous level
- write_enable  in  1  MCU direction: 1 = write, 0 = read
- address  in  AW  MCU register address
- data_in  in  DW  pad input side of the data bus
- data_out  out  DW  pad output side of the data bus (read data)
- data_oe  out  1  pad output enable; 1 = FPGA drives the bus
- fpga_ack  out  1  four-phase acknowledge to the MCU
- int_req  in  1  internal request level, held until int_done
- int_we  in  1  internal direction
- int_addr  in  AW  internal address
- int_wdata  in  DW  internal write data
- int_done  out  1  one-cycle completion pulse
- int_rdata  out  DW  internal read data, valid from int_done until the next internal access
- reg_we  out  1  bank write strobe
- reg_addr  out  AW  bank address
- reg_wdata  out  DW  bank write data
- reg_rdata  in  DW  bank read data, combinational from reg_addr
- addr_err  out  1  one-cycle pulse on an out-of-range access from either side

## Operation
- mcu_mstr passes through a SYNC-flop synchronizer to give mstr_s. address, write_enable and data_in are sampled unsynchronized, and only in MCU_SETUP. The MCU keeps them stable from strobe assertion until it sees fpga_ack.
- FSM states: IDLE, MCU_SETUP, MCU_ACCESS, MCU_ACK, INT_ACCESS, INT_DONE.
- IDLE:
  - If mstr_s and int_req are both set, grant goes to the side not served last. After reset, MCU is treated as served last, so the first tie goes to the internal requester.
  - Otherwise the single requester wins.
  - The MCU request is level-based: mstr_s=1 in IDLE starts a transaction.
- MCU_SETUP: capture address, write_enable and data_in. Drive reg_addr and reg_wdata, and assert reg_we if writing with an in-range address.
- MCU_ACCESS:
  - On a read, capture reg_rdata into data_out, or 8'hFF if out of range, and set data_oe=1.
  - Out-of-range writes are dropped. Any out-of-range access pulses addr_err.
- MCU_ACK: fpga_ack=1. Wait for mstr_s=0, then clear fpga_ack and data_oe and return to IDLE.
- INT_ACCESS: behaves like MCU_SETUP, using the int_* inputs. int_rdata captures reg_rdata, or 8'hFF if out of range.
- INT_DONE: int_done=1 for one cycle, then return to IDLE. If int_req is still high in IDLE, the requester is starting a new transaction.
- reg_we is a single-cycle pulse. Only one access reaches the bank per transaction.

## Timing
- Reset values: data_out=0, data_oe=0, fpga_ack=0, int_done=0, int_rdata=0, reg_we=0, reg_addr=0, reg_wdata=0, addr_err=0. Synchronizer is cleared, FSM is in IDLE.
- Cycle numbering for an MCU transaction:
  - Cycle 0: mstr_s first high in IDLE.
  - Cycle 1: MCU_SETUP; reg_we high if writing.
  - Cycle 2: MCU_ACCESS.
  - Cycle 3: fpga_ack rises. data_oe and data_out are already valid from cycle 3 on a read.
- From pad strobe to ack: SYNC+3 to SYNC+4 clocks.
- Release: fpga_ack and data_oe fall in the cycle after mstr_s is seen low, so SYNC+1 to SYNC+2 clocks after the pad deasserts. The bus is tristated no later than the ack falling.
- Internal transaction: grant in cycle 0, INT_ACCESS in cycle 1 with reg_we, int_done in cycle 2.
- A new grant is possible on the cycle after returning to IDLE. Neither side can block the other for more than one transaction.
- Reset mid-transaction: everything returns to reset values immediately, and data_oe drops asynchronously. If mcu_mstr is still high after reset is released, a new transaction starts.
- If the MCU drops mcu_mstr before ack, the FSM still completes and raises ack. It then sees mstr_s low and releases on the next cycle.

## Test plan
- MCU write, addr 5, data 8'hA5 → reg_we exactly one cycle with reg_addr=5 and reg_wdata=8'hA5. fpga_ack rises 3 cycles after mstr_s. data_oe stays 0.
- MCU read, addr 16, reg_rdata=8'h3C → data_oe=1, data_out=8'h3C, fpga_ack=1. Both fall after mcu_mstr deasserts; fpga_ack falls within SYNC+2 cycles.
- MCU read, addr 20 → data_out=8'hFF, addr_err pulses once, no reg_we.
- mcu_mstr and int_req rise in the same cycle after reset → internal access is served first, then the MCU. Next simultaneous tie → MCU first.
- Internal write, addr 0, 8'h11, with int_req held high → int_done every 3 cycles. MCU requests interleave one-for-one with internal ones.
- RST_N asserted during MCU_ACK of a read → data_oe and fpga_ack go to 0 immediately. With mcu_mstr still high after release, a fresh transaction completes.
